seq_divider: RTL

Parametrised, multi-cycle restoring divider that supersedes the fixed 4-bit combinational divider. It accepts one `WIDTH`-bit dividend/divisor pair through a valid/ready handshake and iterates one quotient bit per clock. It presents quotient, remainder and a divide-by-zero flag through a second valid/ready handshake. It sits between an operand-producing datapath and a result consumer that may apply backpressure.

---
 rtl/div_pkg.sv | 32 +++
 rtl/div_step.sv | 50 +++++
 rtl/seq_divider.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and constant helpers for the sequential restoring divider.
//
// Contents:
//   div_state_t   : FSM state encoding (IDLE, CALC, DONE)
//   cnt_width()   : width of the iteration counter for a given operand width
//   dbz_quotient(): all-ones pattern returned as quotient on divide-by-zero
// -----------------------------------------------------------------------------
package div_pkg;

  // Controller states of seq_divider.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // The counter must be able to hold values 0..WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // All-ones quotient for divide-by-zero, built wide and sliced by the user.
  // Valid for operand widths up to 64 bits.
  function automatic logic [63:0] dbz_quotient(input int w);
    logic [63:0] ones;
    ones = {64{1'b1}};
    return ones >> (64 - w);
  endfunction

endpackage : div_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, compare against the divisor, conditionally subtract
// and produce one quotient bit.
//
// Parameters:
//   WIDTH    : operand width (>= 2)
// Ports:
//   rem_in   : in  [WIDTH-1:0] partial remainder before this step
//   bit_in   : in  1           next dividend bit (MSB first)
//   divisor  : in  [WIDTH-1:0] divisor magnitude
//   rem_out  : out [WIDTH-1:0] partial remainder after this step
//   q_bit    : out 1           quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  // The shifted remainder needs WIDTH+1 bits; the top bit can be set only
  // transiently, since the stored remainder is always below the divisor.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Shift, compare and conditionally subtract.
  always_comb begin
    shifted = {rem_in, bit_in};
    ge      = (shifted >= {1'b0, divisor});
    // When ge holds, the true difference is below 2**WIDTH, so the
    // modulo-2**WIDTH subtraction is exact.
    diff    = shifted[WIDTH-1:0] - divisor;
    if (ge) begin
      rem_out = diff;
      q_bit   = 1'b1;
    end else begin
      rem_out = shifted[WIDTH-1:0];
      q_bit   = 1'b0;
    end
  end

endmodule : div_step

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring divider, one quotient bit per clock, with valid/ready
// handshakes on both the operand and result sides. Only one operation is in
// flight at a time.
//
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN
//   defined   : two's-complement operands; the core divides magnitudes and the
//               signs are fixed on the CALC->DONE edge (truncation toward zero,
//               remainder takes the dividend's sign)
//   undefined : purely unsigned, no sign logic
//
// Parameters:
//   WIDTH       : operand/result width (>= 2)
// Ports:
//   clk         : in  1      rising-edge clock
//   rst         : in  1      synchronous active-high reset
//   in_valid    : in  1      operands valid
//   in_ready    : out 1      block can accept operands (IDLE)
//   dividend    : in  WIDTH  numerator
//   divisor     : in  WIDTH  denominator
//   out_valid   : out 1      result valid (DONE)
//   out_ready   : in  1      consumer accepts result
//   quotient    : out WIDTH  result quotient
//   remainder   : out WIDTH  result remainder
//   div_by_zero : out 1      result came from a zero divisor
//   busy        : out 1      high whenever not IDLE
// -----------------------------------------------------------------------------
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int               CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [63:0]      DBZ_FULL = dbz_quotient(WIDTH);
  localparam logic [WIDTH-1:0] DBZ_Q    = DBZ_FULL[WIDTH-1:0];

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] part_rem;   // partial remainder between steps
  // Dividend bits leave at the top while quotient bits enter at the bottom;
  // after WIDTH steps the register holds the full quotient.
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] dvs;        // divisor magnitude held for the operation

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] start_a;    // dividend magnitude to load at accept
  logic [WIDTH-1:0] start_b;    // divisor magnitude to load at accept
  logic [WIDTH-1:0] fix_q;      // sign-corrected final quotient
  logic [WIDTH-1:0] fix_r;      // sign-corrected final remainder
  logic             accept;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (part_rem),
    .bit_in  (shreg[WIDTH-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Next shift-register value and the operand handshake decode.
  always_comb begin
    shreg_next = {shreg[WIDTH-2:0], step_q};
    accept     = (state == IDLE) && in_valid && in_ready;
  end

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic q_neg;  // quotient must be negated at the end
  logic r_neg;  // remainder must be negated at the end

  // Magnitudes of the incoming operands; MIN maps onto 2**(WIDTH-1), which
  // still fits the unsigned core.
  always_comb begin
    if (dividend[WIDTH-1]) begin
      start_a = ~dividend + ONE;
    end else begin
      start_a = dividend;
    end
    if (divisor[WIDTH-1]) begin
      start_b = ~divisor + ONE;
    end else begin
      start_b = divisor;
    end
  end

  // Sign correction of the unsigned result applied as DONE is entered.
  always_comb begin
    if (q_neg) begin
      fix_q = ~shreg_next + ONE;
    end else begin
      fix_q = shreg_next;
    end
    if (r_neg) begin
      fix_r = ~step_rem + ONE;
    end else begin
      fix_r = step_rem;
    end
  end

  // Capture the operand signs at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (accept) begin
      q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg <= dividend[WIDTH-1];
    end else begin
      q_neg <= q_neg;
      r_neg <= r_neg;
    end
  end
`else
  // Unsigned build: operands and results pass straight through.
  always_comb begin
    start_a = dividend;
    start_b = divisor;
    fix_q   = shreg_next;
    fix_r   = step_rem;
  end
`endif

  // Controller FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= CNT_ZERO;
      part_rem    <= ZERO;
      shreg       <= ZERO;
      dvs         <= ZERO;
      quotient    <= ZERO;
      remainder   <= ZERO;
      div_by_zero <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt         <= CNT_ZERO;
            part_rem    <= ZERO;
            shreg       <= start_a;
            dvs         <= start_b;
            in_ready    <= 1'b0;
            busy        <= 1'b1;
            if (divisor == ZERO) begin
              // No iterations: the result is known immediately.
              state       <= DONE;
              quotient    <= DBZ_Q;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
            end else begin
              state       <= CALC;
              div_by_zero <= 1'b0;
              out_valid   <= 1'b0;
            end
          end else begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        CALC: begin
          part_rem <= step_rem;
          shreg    <= shreg_next;
          cnt      <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            quotient  <= fix_q;
            remainder <= fix_r;
            out_valid <= 1'b1;
          end else begin
            state     <= CALC;
            out_valid <= 1'b0;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state     <= DONE;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule : seq_divider
